// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the cpu16 memory arbiter: grant encoding and region selects.
package mem_map_pkg;

  typedef enum logic [2:0] {
    G_NONE,
    G_DBG,
    G_DAT_RD,
    G_DAT_WR,
    G_INS
  } grant_t;

  localparam logic [3:0]  REGION_SRAM       = 4'h0;
  localparam logic [3:0]  REGION_VRAM       = 4'h8;
  localparam logic [3:0]  REGION_CTRL       = 4'hF;
  localparam logic [15:0] UNMAPPED_DATA_DEF = 16'hEEEE;

  function automatic logic is_cpu_grant(input grant_t g);
    return (g == G_DAT_RD) || (g == G_DAT_WR) || (g == G_INS);
  endfunction

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// Combinational grant select: debug first, then data vs fetch ordered by last_grant.
module cpu_mem_arb_pick
  import mem_map_pkg::*;
(
  input  logic   dbg_we,
  input  logic   dat_rd_req,
  input  logic   dat_wr_req,
  input  logic   ins_rd_req,
  input  logic   dat_mask,
  input  logic   ins_mask,
  input  grant_t last_grant,
  output grant_t grant
);

  logic dat_ok;
  logic ins_ok;
  logic dat_first;

  assign dat_ok    = (dat_rd_req | dat_wr_req) & ~dat_mask;
  assign ins_ok    = ins_rd_req & ~ins_mask;
  // Data goes first unless it was the last CPU source served.
  assign dat_first = (last_grant == G_INS);

  always_comb begin
    grant = G_NONE;
    if (dbg_we) begin
      grant = G_DBG;
    end else if (dat_ok && (!ins_ok || dat_first)) begin
      grant = dat_wr_req ? G_DAT_WR : G_DAT_RD;
    end else if (ins_ok) begin
      grant = G_INS;
    end
  end

endmodule

// File: rtl/cpu_mem_arb.sv
// Single-port SRAM arbiter for cpu16 fetch, data and debug-write sources.
// Define CPU_MEM_ARB_RR_EN for round-robin data/fetch arbitration; default is fixed data > fetch.
module cpu_mem_arb
  import mem_map_pkg::*;
#(
  parameter int            AW            = 16,
  parameter int            DW            = 16,
  parameter logic [3:0]    SRAM_SEL      = REGION_SRAM,
  parameter logic [DW-1:0] UNMAPPED_DATA = UNMAPPED_DATA_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ins_rd_addr,
  input  logic          ins_rd_req,
  output logic          ins_rd_rdy,
  output logic [DW-1:0] ins_rd_data,
  input  logic [AW-1:0] dat_rw_addr,
  input  logic [DW-1:0] dat_wr_data,
  input  logic          dat_rd_req,
  input  logic          dat_wr_req,
  output logic          dat_rd_rdy,
  output logic          dat_wr_rdy,
  output logic [DW-1:0] dat_rd_data,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_waddr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata
);

  grant_t        grant;
  grant_t        last_grant;
  logic          ins_hit;
  logic          dat_hit;
  logic          dbg_hit;
  logic          ins_map_q;
  logic          dat_map_q;
  logic [DW-1:0] ins_hold;
  logic [DW-1:0] dat_hold;

  assign ins_hit = (ins_rd_addr[AW-1 -: 4] == SRAM_SEL);
  assign dat_hit = (dat_rw_addr[AW-1 -: 4] == SRAM_SEL);
  assign dbg_hit = (dbg_waddr[AW-1 -: 4] == SRAM_SEL);

`ifdef CPU_MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= G_INS;
    end else if (is_cpu_grant(grant)) begin
      last_grant <= grant;
    end
  end
`else
  assign last_grant = G_INS;
`endif

  // A source is masked during its own rdy cycle so a still-high req is not served twice.
  cpu_mem_arb_pick u_pick (
    .dbg_we     (dbg_we),
    .dat_rd_req (dat_rd_req),
    .dat_wr_req (dat_wr_req),
    .ins_rd_req (ins_rd_req),
    .dat_mask   (dat_rd_rdy | dat_wr_rdy),
    .ins_mask   (ins_rd_rdy),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    mem_addr  = ins_rd_addr;
    mem_wdata = dat_wr_data;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (grant)
      G_DBG: begin
        mem_addr  = dbg_waddr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_hit & reset_n;
      end
      G_DAT_WR: begin
        mem_addr = dat_rw_addr;
        mem_we   = dat_hit & reset_n;
      end
      G_DAT_RD: begin
        mem_addr = dat_rw_addr;
        mem_re   = dat_hit & reset_n;
      end
      G_INS: begin
        mem_re = ins_hit & reset_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins_rd_rdy <= 1'b0;
      dat_rd_rdy <= 1'b0;
      dat_wr_rdy <= 1'b0;
      ins_map_q  <= 1'b0;
      dat_map_q  <= 1'b0;
      ins_hold   <= '0;
      dat_hold   <= '0;
    end else begin
      ins_rd_rdy <= (grant == G_INS);
      dat_rd_rdy <= (grant == G_DAT_RD);
      dat_wr_rdy <= (grant == G_DAT_WR);
      ins_map_q  <= ins_hit;
      dat_map_q  <= dat_hit;
      if (ins_rd_rdy) ins_hold <= ins_rd_data;
      if (dat_rd_rdy) dat_hold <= dat_rd_data;
    end
  end

  // The SRAM output only changes on mem_re, so a debug write in the rdy cycle leaves it intact.
  assign ins_rd_data = ins_rd_rdy ? (ins_map_q ? mem_rdata : UNMAPPED_DATA) : ins_hold;
  assign dat_rd_data = dat_rd_rdy ? (dat_map_q ? mem_rdata : UNMAPPED_DATA) : dat_hold;

endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed scoreboard bench for cpu_mem_arb with a behavioural single-port SRAM.
module tb_cpu_mem_arb;

  logic        clk;
  logic        reset_n;
  logic [15:0] ins_rd_addr;
  logic        ins_rd_req;
  logic        ins_rd_rdy;
  logic [15:0] ins_rd_data;
  logic [15:0] dat_rw_addr;
  logic [15:0] dat_wr_data;
  logic        dat_rd_req;
  logic        dat_wr_req;
  logic        dat_rd_rdy;
  logic        dat_wr_rdy;
  logic [15:0] dat_rd_data;
  logic        dbg_we;
  logic [15:0] dbg_waddr;
  logic [15:0] dbg_wdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  logic [15:0] sram [0:4095];

  int checks = 0;
  int failures = 0;
  int ins_cnt = 0;
  int dat_cnt = 0;
  int wr_cnt = 0;
  int wr_pend = 0;
  int snap_ins;
  int snap_dat;
  logic [15:0] ins_q[$];
  logic [15:0] dat_q[$];
  logic [15:0] last_ins;
  logic [15:0] last_dat;
  logic [15:0] mon_e;

  cpu_mem_arb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ins_rd_addr (ins_rd_addr),
    .ins_rd_req  (ins_rd_req),
    .ins_rd_rdy  (ins_rd_rdy),
    .ins_rd_data (ins_rd_data),
    .dat_rw_addr (dat_rw_addr),
    .dat_wr_data (dat_wr_data),
    .dat_rd_req  (dat_rd_req),
    .dat_wr_req  (dat_wr_req),
    .dat_rd_rdy  (dat_rd_rdy),
    .dat_wr_rdy  (dat_wr_rdy),
    .dat_rd_data (dat_rd_data),
    .dbg_we      (dbg_we),
    .dbg_waddr   (dbg_waddr),
    .dbg_wdata   (dbg_wdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every rdy pulse, checks hold otherwise.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_ins = '0;
      last_dat = '0;
    end else begin
      if (ins_rd_rdy) begin
        ins_cnt++;
        chk("ins_spurious_rdy", ins_q.size() != 0, 1);
        if (ins_q.size() != 0) begin
          mon_e = ins_q.pop_front();
          chk("ins_rd_data", ins_rd_data, mon_e);
          last_ins = mon_e;
        end
      end else begin
        chk("ins_hold", ins_rd_data, last_ins);
      end
      if (dat_rd_rdy) begin
        dat_cnt++;
        chk("dat_spurious_rdy", dat_q.size() != 0, 1);
        if (dat_q.size() != 0) begin
          mon_e = dat_q.pop_front();
          chk("dat_rd_data", dat_rd_data, mon_e);
          last_dat = mon_e;
        end
      end else begin
        chk("dat_hold", dat_rd_data, last_dat);
      end
      if (dat_wr_rdy) begin
        wr_cnt++;
        chk("wr_spurious_rdy", wr_pend > 0, 1);
        if (wr_pend > 0) wr_pend--;
      end
    end
  end

  task automatic ins_read(input logic [15:0] a, input logic [15:0] e);
    int n;
    @(posedge clk); #1;
    ins_rd_addr = a;
    ins_rd_req  = 1'b1;
    ins_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ins_rd_rdy && n < 20);
    chk("ins_read_timeout", ins_rd_rdy, 1);
    @(posedge clk); #1;
    ins_rd_req = 1'b0;
  endtask

  task automatic dat_read(input logic [15:0] a, input logic [15:0] e);
    int n;
    @(posedge clk); #1;
    dat_rw_addr = a;
    dat_rd_req  = 1'b1;
    dat_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dat_rd_rdy && n < 20);
    chk("dat_read_timeout", dat_rd_rdy, 1);
    @(posedge clk); #1;
    dat_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n = 1'b0;
    ins_rd_addr = '0; ins_rd_req = 1'b0;
    dat_rw_addr = '0; dat_wr_data = '0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ins_rdy", ins_rd_rdy, 0);
    chk("rst_dat_rdy", dat_rd_rdy, 0);
    chk("rst_wr_rdy", dat_wr_rdy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Preload SRAM[0x10] through the debug port.
    @(posedge clk); #1;
    dbg_we = 1'b1; dbg_waddr = 16'h0010; dbg_wdata = 16'h1234;
    @(negedge clk);
    chk("preload_we", mem_we, 1);
    @(posedge clk); #1 dbg_we = 1'b0;

    // Single fetch: mem_re in T, one rdy pulse in T+1.
    @(posedge clk); #1;
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1; ins_q.push_back(16'h1234);
    @(negedge clk);
    chk("t1_mem_re", mem_re, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_rdy_in_T", ins_rd_rdy, 0);
    @(negedge clk);
    chk("t1_rdy_T1", ins_rd_rdy, 1);
    @(posedge clk); #1 ins_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_one_pulse", ins_cnt, 1);

    // Write and fetch together: write first, fetch served in the write's rdy cycle.
    @(posedge clk); #1;
    dat_rw_addr = 16'h0005; dat_wr_data = 16'hBEEF; dat_wr_req = 1'b1; wr_pend++;
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1; ins_q.push_back(16'h1234);
    @(negedge clk);
    chk("t2_we", mem_we, 1);
    chk("t2_waddr", mem_addr, 16'h0005);
    chk("t2_wdata", mem_wdata, 16'hBEEF);
    chk("t2_no_re", mem_re, 0);
    @(negedge clk);
    chk("t2_wr_rdy", dat_wr_rdy, 1);
    chk("t2_ins_re", mem_re, 1);
    chk("t2_ins_addr", mem_addr, 16'h0010);
    @(posedge clk); #1 dat_wr_req = 1'b0;
    @(negedge clk);
    chk("t2_ins_rdy", ins_rd_rdy, 1);
    chk("t2_masked", mem_re, 0);
    @(posedge clk); #1 ins_rd_req = 1'b0;
    dat_read(16'h0005, 16'hBEEF);

    // Debug writes hold off a pending data read for three cycles.
    @(posedge clk); #1;
    dat_rw_addr = 16'h0022; dat_rd_req = 1'b1; dat_q.push_back(16'hCAF2);
    for (int i = 0; i < 3; i++) begin
      dbg_we = 1'b1;
      dbg_waddr = 16'h0020 + 16'(i);
      dbg_wdata = 16'hCAF0 + 16'(i);
      @(negedge clk);
      chk("t3_dbg_we", mem_we, 1);
      chk("t3_dbg_addr", mem_addr, 16'h0020 + 16'(i));
      chk("t3_no_cpu_re", mem_re, 0);
      chk("t3_no_rdy", dat_rd_rdy, 0);
      @(posedge clk); #1;
    end
    dbg_we = 1'b0;
    @(negedge clk);
    chk("t3_dat_re", mem_re, 1);
    chk("t3_dat_addr", mem_addr, 16'h0022);
    @(negedge clk);
    chk("t3_dat_rdy", dat_rd_rdy, 1);
    @(posedge clk); #1 dat_rd_req = 1'b0;
    chk("t3_sram20", sram[12'h020], 16'hCAF0);
    chk("t3_sram21", sram[12'h021], 16'hCAF1);

    // Debug write during the rdy cycle of a fetch must not disturb its data.
    @(posedge clk); #1;
    ins_rd_addr = 16'h0020; ins_rd_req = 1'b1; ins_q.push_back(16'hCAF0);
    @(negedge clk);
    chk("t3b_re", mem_re, 1);
    @(posedge clk); #1;
    dbg_we = 1'b1; dbg_waddr = 16'h0020; dbg_wdata = 16'h5555;
    @(negedge clk);
    chk("t3b_rdy", ins_rd_rdy, 1);
    @(posedge clk); #1;
    dbg_we = 1'b0; ins_rd_req = 1'b0;
    chk("t3b_sram", sram[12'h020], 16'h5555);

    // Unmapped read and write.
    @(posedge clk); #1;
    dat_rw_addr = 16'h8000; dat_rd_req = 1'b1; dat_q.push_back(16'hEEEE);
    @(negedge clk);
    chk("t4_unmapped_no_re", mem_re, 0);
    @(negedge clk);
    chk("t4_unmapped_rdy", dat_rd_rdy, 1);
    @(posedge clk); #1 dat_rd_req = 1'b0;
    @(posedge clk); #1;
    dat_rw_addr = 16'hF000; dat_wr_data = 16'h1111; dat_wr_req = 1'b1; wr_pend++;
    @(negedge clk);
    chk("t4_unmapped_no_we", mem_we, 0);
    @(negedge clk);
    chk("t4_unmapped_wr_rdy", dat_wr_rdy, 1);
    @(posedge clk); #1 dat_wr_req = 1'b0;

    // Both CPU sources held high: grants alternate dat, ins starting with dat.
    ins_read(16'h0010, 16'h1234);
    repeat (2) @(negedge clk);
    snap_ins = ins_cnt;
    snap_dat = dat_cnt;
    @(posedge clk); #1;
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    dat_rw_addr = 16'h0005; dat_rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_alt_re", mem_re, 1);
      if (i % 2 == 0) begin
        chk("t5_alt_dat", mem_addr, 16'h0005);
        dat_q.push_back(16'hBEEF);
      end else begin
        chk("t5_alt_ins", mem_addr, 16'h0010);
        ins_q.push_back(16'h1234);
      end
    end
    @(posedge clk); #1;
    ins_rd_req = 1'b0; dat_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_ins_pulses", ins_cnt, snap_ins + 4);
    chk("t5_dat_pulses", dat_cnt, snap_dat + 4);

    // Reset during the rdy cycle of a fetch.
    @(posedge clk); #1;
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    @(negedge clk);
    chk("t6_re", mem_re, 1);
    @(posedge clk); #1;
    reset_n = 1'b0; ins_rd_req = 1'b0;
    #1;
    chk("t6_rdy_drop", ins_rd_rdy, 0);
    chk("t6_re_drop", mem_re, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    snap_ins = ins_cnt;
    repeat (3) @(negedge clk);
    chk("t6_no_stale", ins_cnt, snap_ins);
    ins_read(16'h0010, 16'h1234);
    repeat (2) @(negedge clk);

    chk("end_ins_q_empty", ins_q.size(), 0);
    chk("end_dat_q_empty", dat_q.size(), 0);
    chk("end_wr_pend", wr_pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
